// File: rtl/uart_frame_streamer_if.sv
// Read-port and byte-UART signals between the frame streamer and its neighbours.
// The master side is the streamer. The slave side is the frame buffer plus the UART.
`timescale 1ns/1ps
interface uart_frame_streamer_if #(
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int WORD_BYTES = 4
);
    logic [X_W-1:0]          rd_x_o;
    logic [Y_W-1:0]          rd_y_o;
    logic [8*WORD_BYTES-1:0] rd_data_i;
    logic                    uart_busy_i;
    logic                    uart_wr_o;
    logic [7:0]              uart_dat_o;

    modport master (
        output rd_x_o, rd_y_o, uart_wr_o, uart_dat_o,
        input  rd_data_i, uart_busy_i
    );

    modport slave (
        input  rd_x_o, rd_y_o, uart_wr_o, uart_dat_o,
        output rd_data_i, uart_busy_i
    );
endinterface

// File: rtl/uart_frame_streamer.sv
// Raster-scans a COLS x ROWS word buffer and streams each word byte-by-byte to a byte UART.
// An optional sync header is sent first. The byte order is selectable, and a frame is started by a trigger or runs continuously.
`timescale 1ns/1ps
module uart_frame_streamer #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter int         X_W        = 6,
    parameter int         Y_W        = 5,
    parameter int         WORD_BYTES = 4,
    parameter int         HOLDOFF_W  = 13,
    parameter int         HEADER_EN  = 1,
    parameter logic [7:0] HEADER0    = 8'hA5,
    parameter logic [7:0] HEADER1    = 8'h5A,
    parameter int         MSB_FIRST  = 1,
    parameter int         CONTINUOUS = 1
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic frame_done_o,
    uart_frame_streamer_if.master bus
);
    localparam int             Z_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [Z_W-1:0] Z_LAST = Z_W'(WORD_BYTES - 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_LATCH, S_SEND, S_DONE
    } state_t;

    state_t                  state_reg;
    logic [X_W-1:0]          x_reg;
    logic [Y_W-1:0]          y_reg;
    logic [Z_W-1:0]          z_reg;
    logic [8*WORD_BYTES-1:0] word_reg;
    logic [HOLDOFF_W-1:0]    holdoff_reg;
    logic                    wr_reg;
    logic [7:0]              dat_reg;
    logic                    busy_reg;
    logic                    done_reg;

    logic [7:0]     word_bytes [WORD_BYTES];
    logic [Z_W-1:0] byte_sel;
    logic [7:0]     send_byte;
    logic           can_send;
    logic           go;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign byte_sel  = (MSB_FIRST != 0) ? (Z_LAST - z_reg) : z_reg;
    assign send_byte = word_bytes[byte_sel];
    // The wr_reg term keeps two strobes from landing in adjacent cycles before the UART reports busy.
    assign can_send  = (&holdoff_reg) && !bus.uart_busy_i && !wr_reg;
    assign go        = (CONTINUOUS != 0) || start_i;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            holdoff_reg <= '0;
        end else if (bus.uart_busy_i) begin
            holdoff_reg <= '0;
        end else if (!(&holdoff_reg)) begin
            holdoff_reg <= holdoff_reg + HOLDOFF_W'(1);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            word_reg  <= '0;
            wr_reg    <= 1'b0;
            dat_reg   <= 8'h00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            wr_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        x_reg     <= '0;
                        y_reg     <= '0;
                        z_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= (HEADER_EN != 0) ? S_HDR0 : S_FETCH;
                    end
                end
                S_HDR0: begin
                    if (can_send) begin
                        wr_reg    <= 1'b1;
                        dat_reg   <= HEADER0;
                        state_reg <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (can_send) begin
                        wr_reg    <= 1'b1;
                        dat_reg   <= HEADER1;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: state_reg <= S_LATCH;
                S_LATCH: begin
                    word_reg  <= bus.rd_data_i;
                    state_reg <= S_SEND;
                end
                S_SEND: begin
                    if (can_send) begin
                        wr_reg  <= 1'b1;
                        dat_reg <= send_byte;
                        if (z_reg != Z_LAST) begin
                            z_reg <= z_reg + Z_W'(1);
                        end else begin
                            z_reg <= '0;
                            if (x_reg == X_LAST && y_reg == Y_LAST) begin
                                state_reg <= S_DONE;
                            end else if (x_reg == X_LAST) begin
                                x_reg     <= '0;
                                y_reg     <= y_reg + Y_W'(1);
                                state_reg <= S_FETCH;
                            end else begin
                                x_reg     <= x_reg + X_W'(1);
                                state_reg <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_x_o     = x_reg;
    assign bus.rd_y_o     = y_reg;
    assign bus.uart_wr_o  = wr_reg;
    assign bus.uart_dat_o = dat_reg;
    assign busy_o         = busy_reg;
    assign frame_done_o   = done_reg;
endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench driving three streamers, one each for one-shot MSB-first, headerless LSB-first and continuous.
// All three use 2x2 frames of 32-bit words, and each has its own buffer and UART model (busy 10 cycles per byte).
`timescale 1ns/1ps
module tb_uart_frame_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] EXP_MSB [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12, 8'h23, 8'h34, 8'h45,
                                            8'h21, 8'h32, 8'h43, 8'h54, 8'h22, 8'h33, 8'h44, 8'h55};
    localparam logic [7:0] EXP_LSB [16] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h45, 8'h34, 8'h23, 8'h12,
                                            8'h54, 8'h43, 8'h32, 8'h21, 8'h55, 8'h44, 8'h33, 8'h22};

    logic [2:0]  rst_v   = 3'b111;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  force_v = 3'b000;
    logic [2:0]  busyo_v, fd_v, wr_v, busyi_v, rdx_v, rdy_v;
    logic [7:0]  dat_v [3];
    logic [31:0] rdd_v [3];

    int         ucnt      [3] = '{0, 0, 0};
    int         log_n     [3] = '{0, 0, 0};
    int         done_n    [3] = '{0, 0, 0};
    int         adj_n     [3] = '{0, 0, 0};
    int         viol_n    [3] = '{0, 0, 0};
    int         min_gap   [3] = '{1000, 1000, 1000};
    int         last_busy [3] = '{-1000, -1000, -1000};
    logic [7:0] log_mem   [3][256];
    logic [2:0] prev_wr   = 3'b000;
    logic [2:0] prev_busy = 3'b000;
    int         cyc       = 0;

    int vec_n  = 0;
    int miss_n = 0;

    uart_frame_streamer_if #(.X_W(1), .Y_W(1), .WORD_BYTES(4)) bus_a ();
    uart_frame_streamer_if #(.X_W(1), .Y_W(1), .WORD_BYTES(4)) bus_b ();
    uart_frame_streamer_if #(.X_W(1), .Y_W(1), .WORD_BYTES(4)) bus_c ();

    uart_frame_streamer #(.COLS(2), .ROWS(2), .X_W(1), .Y_W(1), .WORD_BYTES(4), .HOLDOFF_W(2),
        .HEADER_EN(1), .HEADER0(8'hA5), .HEADER1(8'h5A), .MSB_FIRST(1), .CONTINUOUS(0)) u_a (
        .sys_clk_i(clk), .sys_rst_i(rst_v[0]), .start_i(start_v[0]),
        .busy_o(busyo_v[0]), .frame_done_o(fd_v[0]), .bus(bus_a));
    uart_frame_streamer #(.COLS(2), .ROWS(2), .X_W(1), .Y_W(1), .WORD_BYTES(4), .HOLDOFF_W(2),
        .HEADER_EN(0), .HEADER0(8'hA5), .HEADER1(8'h5A), .MSB_FIRST(0), .CONTINUOUS(0)) u_b (
        .sys_clk_i(clk), .sys_rst_i(rst_v[1]), .start_i(start_v[1]),
        .busy_o(busyo_v[1]), .frame_done_o(fd_v[1]), .bus(bus_b));
    uart_frame_streamer #(.COLS(2), .ROWS(2), .X_W(1), .Y_W(1), .WORD_BYTES(4), .HOLDOFF_W(2),
        .HEADER_EN(1), .HEADER0(8'hA5), .HEADER1(8'h5A), .MSB_FIRST(1), .CONTINUOUS(1)) u_c (
        .sys_clk_i(clk), .sys_rst_i(rst_v[2]), .start_i(start_v[2]),
        .busy_o(busyo_v[2]), .frame_done_o(fd_v[2]), .bus(bus_c));

    assign bus_a.rd_data_i = rdd_v[0];  assign bus_a.uart_busy_i = busyi_v[0];
    assign bus_b.rd_data_i = rdd_v[1];  assign bus_b.uart_busy_i = busyi_v[1];
    assign bus_c.rd_data_i = rdd_v[2];  assign bus_c.uart_busy_i = busyi_v[2];
    assign wr_v  = {bus_c.uart_wr_o, bus_b.uart_wr_o, bus_a.uart_wr_o};
    assign rdx_v = {bus_c.rd_x_o, bus_b.rd_x_o, bus_a.rd_x_o};
    assign rdy_v = {bus_c.rd_y_o, bus_b.rd_y_o, bus_a.rd_y_o};
    assign dat_v[0] = bus_a.uart_dat_o;
    assign dat_v[1] = bus_b.uart_dat_o;
    assign dat_v[2] = bus_c.uart_dat_o;

    function automatic logic [31:0] mem_word(input logic x, input logic y);
        logic [7:0] d;
        d = {3'b000, y, 3'b000, x};
        return {8'h11 + d, 8'h22 + d, 8'h33 + d, 8'h44 + d};
    endfunction

    always_comb begin
        busyi_v = 3'b000;
        for (int i = 0; i < 3; i++) busyi_v[i] = (ucnt[i] != 0) || force_v[i];
    end

    // Buffer and UART models, plus strobe logging and protocol bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            rdd_v[i] <= mem_word(rdx_v[i], rdy_v[i]);
            if (rst_v[i])           ucnt[i] <= 0;
            else if (wr_v[i])       ucnt[i] <= 10;
            else if (ucnt[i] > 0)   ucnt[i] <= ucnt[i] - 1;
            if (wr_v[i]) begin
                if (log_n[i] < 256) log_mem[i][log_n[i]] <= dat_v[i];
                log_n[i] <= log_n[i] + 1;
                if (prev_wr[i])   adj_n[i]  <= adj_n[i] + 1;
                if (prev_busy[i]) viol_n[i] <= viol_n[i] + 1;
                if (cyc - last_busy[i] < min_gap[i]) min_gap[i] <= cyc - last_busy[i];
            end
            if (busyi_v[i]) last_busy[i] <= cyc;
            if (fd_v[i])    done_n[i] <= done_n[i] + 1;
        end
        prev_wr   <= wr_v;
        prev_busy <= busyi_v;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            miss_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vec_n, tag, obs, exp);
    endtask

    function automatic logic [7:0] get_byte(input int k, input int idx);
        if (idx >= log_n[k] || idx >= 256) return 8'hxx;
        return log_mem[k][idx];
    endfunction

    task automatic check_frame(input int k, input int base, input bit hdr, input bit msb, input string tag);
        int off;
        off = 0;
        if (hdr) begin
            check($sformatf("%s hdr0", tag), 32'(get_byte(k, base)), 32'h A5);
            check($sformatf("%s hdr1", tag), 32'(get_byte(k, base + 1)), 32'h5A);
            off = 2;
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("%s byte%0d", tag, i), 32'(get_byte(k, base + off + i)),
                  32'(msb ? EXP_MSB[i] : EXP_LSB[i]));
    endtask

    task automatic wait_count(input int k, input bit bytes, input int target, input int budget,
                              input string tag);
        int n;
        n = 0;
        while ((bytes ? log_n[k] : done_n[k]) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'((bytes ? log_n[k] : done_n[k]) >= target), 32'd1);
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    initial begin
        int base, d0, s0, s1;
        repeat (3) @(negedge clk);
        check("rst wr",   32'(wr_v[0]), 32'd0);
        check("rst busy", 32'(busyo_v[0]), 32'd0);
        check("rst x",    32'(rdx_v[0]), 32'd0);
        check("rst y",    32'(rdy_v[0]), 32'd0);
        check("rst dat",  32'(dat_v[0]), 32'd0);
        check("rst done", 32'(fd_v[0]), 32'd0);
        rst_v[1:0] = 2'b00;

        // One-shot unit stays silent without a trigger.
        repeat (1000) @(negedge clk);
        check("idle strobes", 32'(log_n[0]), 32'd0);
        check("idle busy",    32'(busyo_v[0]), 32'd0);

        // T1: single MSB-first frame with header.
        base = log_n[0];
        pulse_start(0);
        check("t1 busy", 32'(busyo_v[0]), 32'd1);
        wait_count(0, 1'b0, 1, 2000, "t1 done");
        check("t1 busy end", 32'(busyo_v[0]), 32'd0);
        check("t1 count", 32'(log_n[0] - base), 32'd18);
        check_frame(0, base, 1'b1, 1'b1, "t1");

        // T4: a trigger mid-frame is dropped.
        base = log_n[0];
        d0 = done_n[0];
        pulse_start(0);
        repeat (100) @(negedge clk);
        pulse_start(0);
        wait_count(0, 1'b0, d0 + 1, 2000, "t4 done");
        repeat (500) @(negedge clk);
        check("t4 frames", 32'(done_n[0] - d0), 32'd1);
        check("t4 count",  32'(log_n[0] - base), 32'd18);
        check_frame(0, base, 1'b1, 1'b1, "t4");

        // T3: a long busy stall mid-frame.
        base = log_n[0];
        pulse_start(0);
        wait_count(0, 1'b1, base + 6, 2000, "t3 reach");
        force_v[0] = 1'b1;
        @(negedge clk);
        s0 = log_n[0];
        repeat (49) @(negedge clk);
        s1 = log_n[0];
        force_v[0] = 1'b0;
        check("t3 stall strobes", 32'(s1 - s0), 32'd0);
        wait_count(0, 1'b0, done_n[0] + 1, 2000, "t3 done");
        check("t3 count", 32'(log_n[0] - base), 32'd18);
        check_frame(0, base, 1'b1, 1'b1, "t3");
        check("adjacent strobes", 32'(adj_n[0]), 32'd0);
        check("strobe while busy", 32'(viol_n[0]), 32'd0);
        check("holdoff gap ok", 32'(min_gap[0] >= 4), 32'd1);

        // T6: reset mid-SEND, then a fresh frame.
        base = log_n[0];
        pulse_start(0);
        wait_count(0, 1'b1, base + 3, 2000, "t6 reach");
        rst_v[0] = 1'b1;
        @(negedge clk);
        check("t6 wr",   32'(wr_v[0]), 32'd0);
        check("t6 busy", 32'(busyo_v[0]), 32'd0);
        check("t6 x",    32'(rdx_v[0]), 32'd0);
        check("t6 y",    32'(rdy_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        @(negedge clk);
        base = log_n[0];
        d0 = done_n[0];
        pulse_start(0);
        wait_count(0, 1'b0, d0 + 1, 2000, "t6 done");
        check("t6 count", 32'(log_n[0] - base), 32'd18);
        check_frame(0, base, 1'b1, 1'b1, "t6");

        // T2: LSB-first, headerless.
        pulse_start(1);
        wait_count(1, 1'b0, 1, 2000, "t2 done");
        check("t2 count", 32'(log_n[1]), 32'd16);
        check_frame(1, 0, 1'b0, 1'b0, "t2");
        check("t2 adjacent", 32'(adj_n[1]), 32'd0);

        // T5: continuous mode, three back-to-back frames.
        rst_v[2] = 1'b0;
        wait_count(2, 1'b0, 3, 4000, "t5 done3");
        check("t5 frames", 32'(done_n[2]), 32'd3);
        check("t5 count",  32'(log_n[2]), 32'd54);
        for (int f = 0; f < 3; f++) check_frame(2, 18 * f, 1'b1, 1'b1, $sformatf("t5 f%0d", f));
        check("t5 adjacent", 32'(adj_n[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule
